// File: rtl/frame_fill_arbiter_pkg.sv
// Shared frame-buffer types and constants for the rectangle-fill path.
//   H_RES/V_RES   visible screen size in pixels
//   ADDR_W        frame buffer address width (640*480-1 = 307199 fits in 19 bits)
//   COLOR_W       pixel colour width
//   rect_t        one fill request: top-left corner, size, colour
//   fill_state_t  fill sequencer states
package vv_fb_pkg;

  localparam int H_RES   = 640;
  localparam int V_RES   = 480;
  localparam int ADDR_W  = 19;
  localparam int COLOR_W = 8;
  localparam int COORD_W = 10;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] w;
    logic [COORD_W-1:0] h;
    logic [COLOR_W-1:0] color;
  } rect_t;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    FILL,
    DONE
  } fill_state_t;

endpackage

// File: rtl/frame_fill_arbiter_if.sv
// Bundle between the rectangle-fill requesters / frame buffer and the arbiter.
//   req, req_x/y/w/h, req_color   requester side, packed NUM_REQ-wide
//   ack, done, done_id, busy      grant / completion status
//   wr_address, wr_data, wr_en    frame buffer write port
// master: requester/frame-buffer side; slave: the arbiter.
interface frame_fill_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 19,
  parameter int COLOR_W = 8
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*10-1:0]      req_x;
  logic [NUM_REQ*10-1:0]      req_y;
  logic [NUM_REQ*10-1:0]      req_w;
  logic [NUM_REQ*10-1:0]      req_h;
  logic [NUM_REQ*COLOR_W-1:0] req_color;
  logic [NUM_REQ-1:0]         ack;
  logic                       done;
  logic [ID_W-1:0]            done_id;
  logic                       busy;
  logic [ADDR_W-1:0]          wr_address;
  logic [COLOR_W-1:0]         wr_data;
  logic                       wr_en;

  modport master (
    output req, req_x, req_y, req_w, req_h, req_color,
    input  ack, done, done_id, busy, wr_address, wr_data, wr_en
  );

  modport slave (
    input  req, req_x, req_y, req_w, req_h, req_color,
    output ack, done, done_id, busy, wr_address, wr_data, wr_en
  );

endinterface

// File: rtl/frame_fill_arbiter_rr.sv
// Combinational round-robin selector.
//   req          request vector
//   pointer      highest-priority index this round
//   grant_valid  some request is pending
//   grant_idx    first requester at or after pointer (wrapping)
module rr_arbiter #(
  parameter  int NUM_REQ = 3,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    pointer,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_idx
);

  int              pos;
  logic [ID_W-1:0] idx;

  // Walk from the farthest candidate back to the pointer so the closest
  // pending requester is the last (and winning) assignment.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    pos         = 0;
    idx         = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = int'(pointer) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      idx = ID_W'(pos);
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/frame_fill_arbiter.sv
// Sole owner of the frame buffer write port. Round-robin shares it among
// NUM_REQ rectangle-fill requesters; each granted rect is clipped to the
// screen and written one pixel per clock in raster order.
//   Clk, Reset  system clock, asynchronous active-high reset
//   bus         frame_fill_arbiter_if slave: requests in, ack/done/busy and
//               wr_address/wr_data/wr_en out
module frame_fill_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int H_RES   = vv_fb_pkg::H_RES,
  parameter int V_RES   = vv_fb_pkg::V_RES,
  parameter int ADDR_W  = vv_fb_pkg::ADDR_W,
  parameter int COLOR_W = vv_fb_pkg::COLOR_W
) (
  input  logic                 Clk,
  input  logic                 Reset,
  frame_fill_arbiter_if.slave  bus
);
  import vv_fb_pkg::*;

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  fill_state_t        state;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    gidx;
  logic               grant_valid;
  logic [ID_W-1:0]    grant_idx;

  logic [10:0]        x0, x_end, y_end, cur_x, cur_y;
  logic [ADDR_W-1:0]  row_base, pix_addr;
  logic [COLOR_W-1:0] color;

  rect_t              sel;
  logic [10:0]        x_sum, y_sum, clip_x_end, clip_y_end;
  logic               clip_empty;
  logic [ADDR_W-1:0]  sel_row_base;
  logic               last_col, last_row;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req         (bus.req),
    .pointer     (ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Fields of the granted requester, clipped with 11-bit sums so x+w cannot wrap.
  always_comb begin
    sel.x        = bus.req_x[gidx*10 +: 10];
    sel.y        = bus.req_y[gidx*10 +: 10];
    sel.w        = bus.req_w[gidx*10 +: 10];
    sel.h        = bus.req_h[gidx*10 +: 10];
    sel.color    = bus.req_color[gidx*COLOR_W +: COLOR_W];
    x_sum        = {1'b0, sel.x} + {1'b0, sel.w};
    y_sum        = {1'b0, sel.y} + {1'b0, sel.h};
    clip_x_end   = (x_sum > 11'(H_RES)) ? 11'(H_RES) : x_sum;
    clip_y_end   = (y_sum > 11'(V_RES)) ? 11'(V_RES) : y_sum;
    clip_empty   = (sel.w == '0) || (sel.h == '0) ||
                   ({1'b0, sel.x} >= 11'(H_RES)) || ({1'b0, sel.y} >= 11'(V_RES));
    sel_row_base = ADDR_W'(sel.y) * ADDR_W'(H_RES);
  end

  assign last_col = (cur_x == x_end - 11'd1);
  assign last_row = (cur_y == y_end - 11'd1);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state          <= IDLE;
      ptr            <= '0;
      gidx           <= '0;
      x0             <= '0;
      x_end          <= '0;
      y_end          <= '0;
      cur_x          <= '0;
      cur_y          <= '0;
      row_base       <= '0;
      pix_addr       <= '0;
      color          <= '0;
      bus.ack        <= '0;
      bus.done       <= 1'b0;
      bus.done_id    <= '0;
      bus.busy       <= 1'b0;
      bus.wr_address <= '0;
      bus.wr_data    <= '0;
      bus.wr_en      <= 1'b0;
    end else begin
      bus.ack  <= '0;
      bus.done <= 1'b0;
      bus.wr_en <= 1'b0;
      case (state)
        IDLE: begin
          bus.busy <= 1'b0;
          if (grant_valid) begin
            gidx  <= grant_idx;
            state <= GRANT;
          end
        end
        GRANT: begin
          // A requester that withdrew before its ack is not served.
          if (!bus.req[gidx]) begin
            state <= IDLE;
          end else begin
            bus.ack  <= NUM_REQ'(1) << gidx;
            bus.busy <= 1'b1;
            color    <= sel.color;
            x0       <= {1'b0, sel.x};
            cur_x    <= {1'b0, sel.x};
            cur_y    <= {1'b0, sel.y};
            x_end    <= clip_x_end;
            y_end    <= clip_y_end;
            row_base <= sel_row_base;
            pix_addr <= sel_row_base + ADDR_W'(sel.x);
            state    <= clip_empty ? DONE : FILL;
          end
        end
        FILL: begin
          bus.wr_en      <= 1'b1;
          bus.wr_address <= pix_addr;
          bus.wr_data    <= color;
          if (last_col) begin
            cur_x    <= x0;
            cur_y    <= cur_y + 11'd1;
            row_base <= row_base + ADDR_W'(H_RES);
            pix_addr <= row_base + ADDR_W'(H_RES) + ADDR_W'(x0);
            if (last_row) state <= DONE;
          end else begin
            cur_x    <= cur_x + 11'd1;
            pix_addr <= pix_addr + ADDR_W'(1);
          end
        end
        DONE: begin
          bus.done    <= 1'b1;
          bus.done_id <= gidx;
          ptr         <= (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + ID_W'(1);
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
